md_sched: RTL

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched_pkg.sv | 31 +++
 rtl/md_sched.sv | 112 +++++++++++
 2 files changed

// File: rtl/md_sched_pkg.sv
// Shared multiply/divide op encodings and latencies for the MD scheduler.
// Used by both the controller and anything else decoding Multop fields.
package md_sched_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } multop_e;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_CYC = 4'd5;
  localparam logic [CNT_W-1:0] DIV_CYC  = 4'd10;

  // Ops that launch the multi-cycle unit.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Any op touching HI/LO; these must wait while the unit is busy.
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: result computed at issue, committed after a
// fixed latency window measured by a down-counter; drives pipeline stall.
module md_sched
  import md_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [3:0]  MultopE,
  input  logic [3:0]  MultopD,
  input  logic [31:0] R1E,
  input  logic [31:0] R2E,
  input  logic        Req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut,
  output logic        Busy,
  output logic        StallMD
);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_ok_q, pend_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             busy;
  logic             accept;
  logic             is_div;
  logic             div_ovf;
  logic [31:0]      div_b;
  logic [63:0]      prod_s, prod_u;
  logic signed [31:0] sq, sr;
  logic [31:0]      uq, ur;

  assign busy   = (cnt_q != '0);
  assign accept = StartE && is_md_op(MultopE) && !busy && !Req;
  assign is_div = (MultopE == OP_DIV) || (MultopE == OP_DIVU);

  always_comb begin
    prod_s = $signed({{32{R1E[31]}}, R1E}) * $signed({{32{R2E[31]}}, R2E});
    prod_u = {32'd0, R1E} * {32'd0, R2E};
    // Substitute a harmless divisor for /0 and INT_MIN/-1 so the divider never traps.
    div_ovf = (R1E == 32'h8000_0000) && (R2E == 32'hFFFF_FFFF);
    div_b   = ((R2E == '0) || div_ovf) ? 32'd1 : R2E;
    sq = $signed(R1E) / $signed(div_b);
    sr = $signed(R1E) % $signed(div_b);
    if (div_ovf) begin
      sq = $signed(R1E);
      sr = '0;
    end
    uq = R1E / div_b;
    ur = R1E % div_b;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    cnt_d     = cnt_q;
    if (accept) begin
      cnt_d     = is_div ? DIV_CYC : MULT_CYC;
      pend_ok_d = !(is_div && (R2E == '0));
      unique case (MultopE)
        OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
        OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
        OP_DIV:   {pend_hi_d, pend_lo_d} = {sr, sq};
        default:  {pend_hi_d, pend_lo_d} = {ur, uq};
      endcase
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == 1) && pend_ok_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!StartE && !Req) begin
      if (MultopE == OP_MTHI) hi_d = R1E;
      if (MultopE == OP_MTLO) lo_d = R1E;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    MDOut = '0;
    if (MultopE == OP_MFHI) MDOut = hi_q;
    if (MultopE == OP_MFLO) MDOut = lo_q;
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = busy;
  assign StallMD = is_hilo_op(MultopD) && (busy || accept);

endmodule
